// File: rtl/bcd_modcnt.sv
// Two-digit packed-BCD up/down modulo counter spanning MIN_VAL..MAX_VAL with
// combinational carry/borrow for cascading. Optional time-set load: BCD_MODCNT_LOAD_EN.
module bcd_modcnt #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
`ifdef BCD_MODCNT_LOAD_EN
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic       load_err,
`endif
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       co,
  output logic       bo,
  output logic       at_max,
  output logic       at_min
);

  if (MIN_VAL < 0 || MIN_VAL > 98 || MAX_VAL <= MIN_VAL || MAX_VAL > 99) begin : g_bad_param
    $error("bcd_modcnt: illegal MIN_VAL/MAX_VAL combination");
  end

  localparam logic [3:0] MIN_T = 4'(MIN_VAL / 10);
  localparam logic [3:0] MIN_O = 4'(MIN_VAL % 10);
  localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;
  logic       w_at_max;
  logic       w_at_min;
  logic       w_step;

  // Wrap decisions compare both digits so ranges like 1..12 or 0..23 wrap correctly.
  assign w_at_max = (r_tens == MAX_T) && (r_ones == MAX_O);
  assign w_at_min = (r_tens == MIN_T) && (r_ones == MIN_O);

`ifdef BCD_MODCNT_LOAD_EN
  logic       r_load_err;
  logic       w_load_ok;
  logic [7:0] w_load_bcd;

  // Packed BCD with valid digits orders the same as the decimal value.
  assign w_load_bcd = {load_tens, load_ones};
  assign w_load_ok  = load && (load_tens <= 4'd9) && (load_ones <= 4'd9) &&
                      (w_load_bcd >= {MIN_T, MIN_O}) && (w_load_bcd <= {MAX_T, MAX_O});
  assign w_step     = en && !load;
  assign load_err   = r_load_err;
`else
  assign w_step     = en;
`endif

  assign co     = w_step &&  up && w_at_max;
  assign bo     = w_step && !up && w_at_min;
  assign at_max = w_at_max;
  assign at_min = w_at_min;
  assign tens   = r_tens;
  assign ones   = r_ones;

  always_comb begin
    w_tens_nxt = r_tens;
    w_ones_nxt = r_ones;
    if (w_step) begin
      if (up) begin
        if (w_at_max) begin
          w_tens_nxt = MIN_T;
          w_ones_nxt = MIN_O;
        end else if (r_ones == 4'd9) begin
          w_tens_nxt = r_tens + 4'd1;
          w_ones_nxt = 4'd0;
        end else begin
          w_ones_nxt = r_ones + 4'd1;
        end
      end else begin
        if (w_at_min) begin
          w_tens_nxt = MAX_T;
          w_ones_nxt = MAX_O;
        end else if (r_ones == 4'd0) begin
          w_tens_nxt = r_tens - 4'd1;
          w_ones_nxt = 4'd9;
        end else begin
          w_ones_nxt = r_ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tens <= MIN_T;
      r_ones <= MIN_O;
`ifdef BCD_MODCNT_LOAD_EN
      r_load_err <= 1'b0;
    end else if (load) begin
      // A rejected load keeps the count and flags the error for one cycle.
      if (w_load_ok) begin
        r_tens <= load_tens;
        r_ones <= load_ones;
      end
      r_load_err <= !w_load_ok;
    end else begin
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
      r_load_err <= 1'b0;
`else
    end else begin
      r_tens <= w_tens_nxt;
      r_ones <= w_ones_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_modcnt.sv
// Scoreboard bench for bcd_modcnt: 0..59 counter, 1..12 counter and a cascaded
// secs->mins pair, all checked against an integer reference model.
module tb_bcd_modcnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] lt  = 4'd0;
  logic [3:0] lo  = 4'd0;

  always #5 clk = ~clk;

  logic [3:0] a_t, a_o, b_t, b_o, s_t, s_o, m_t, m_o;
  logic       a_co, a_bo, a_mx, a_mn, b_co, b_bo, b_mx, b_mn;
  logic       s_co, s_bo, s_mx, s_mn, m_co, m_bo, m_mx, m_mn;
`ifdef BCD_MODCNT_LOAD_EN
  logic       a_le, b_le, s_le, m_le;
`endif

  bcd_modcnt #(.MIN_VAL(0), .MAX_VAL(59)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef BCD_MODCNT_LOAD_EN
    .load(ld), .load_tens(lt), .load_ones(lo), .load_err(a_le),
`endif
    .ones(a_o), .tens(a_t), .co(a_co), .bo(a_bo), .at_max(a_mx), .at_min(a_mn));

  bcd_modcnt #(.MIN_VAL(1), .MAX_VAL(12)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up),
`ifdef BCD_MODCNT_LOAD_EN
    .load(1'b0), .load_tens(4'd0), .load_ones(4'd0), .load_err(b_le),
`endif
    .ones(b_o), .tens(b_t), .co(b_co), .bo(b_bo), .at_max(b_mx), .at_min(b_mn));

  bcd_modcnt #(.MIN_VAL(0), .MAX_VAL(59)) u_secs (
    .clk(clk), .rst(rst), .en(en), .up(1'b1),
`ifdef BCD_MODCNT_LOAD_EN
    .load(1'b0), .load_tens(4'd0), .load_ones(4'd0), .load_err(s_le),
`endif
    .ones(s_o), .tens(s_t), .co(s_co), .bo(s_bo), .at_max(s_mx), .at_min(s_mn));

  bcd_modcnt #(.MIN_VAL(0), .MAX_VAL(59)) u_mins (
    .clk(clk), .rst(rst), .en(s_co), .up(1'b1),
`ifdef BCD_MODCNT_LOAD_EN
    .load(1'b0), .load_tens(4'd0), .load_ones(4'd0), .load_err(m_le),
`endif
    .ones(m_o), .tens(m_t), .co(m_co), .bo(m_bo), .at_max(m_mx), .at_min(m_mn));

  typedef struct {
    logic [7:0] a_cnt; logic a_co, a_bo, a_mx, a_mn, a_le;
    logic [7:0] b_cnt; logic b_co, b_bo, b_mx, b_mn;
    logic [7:0] s_cnt, m_cnt; logic m_co;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mco_seen = 0;

  // Reference model state: plain decimal values.
  int   va, vb, vt;
  logic lea;
  bit   mvalid = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int nxt(input int v, input logic u, input int lo_v, input int hi_v);
    if (u) return (v == hi_v) ? lo_v : v + 1;
    return (v == lo_v) ? hi_v : v - 1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step(input logic i_rst, input logic i_en, input logic i_up,
                      input logic i_ld, input logic [3:0] i_lt, input logic [3:0] i_lo);
    exp_t e;
    logic ld_eff, en_a, legal;
    int   lv;
    @(posedge clk);
    #1;
    rst = i_rst; en = i_en; up = i_up; ld = i_ld; lt = i_lt; lo = i_lo;
`ifdef BCD_MODCNT_LOAD_EN
    ld_eff = i_ld;
`else
    ld_eff = 1'b0;
`endif
    en_a = i_en && !ld_eff;
    if (mvalid) begin
      e.a_cnt = to_bcd(va);
      e.a_co  = en_a && i_up && (va == 59);
      e.a_bo  = en_a && !i_up && (va == 0);
      e.a_mx  = (va == 59);
      e.a_mn  = (va == 0);
      e.a_le  = lea;
      e.b_cnt = to_bcd(vb);
      e.b_co  = i_en && i_up && (vb == 12);
      e.b_bo  = i_en && !i_up && (vb == 1);
      e.b_mx  = (vb == 12);
      e.b_mn  = (vb == 1);
      e.s_cnt = to_bcd(vt % 60);
      e.m_cnt = to_bcd(vt / 60);
      e.m_co  = i_en && (vt == 3599);
      sb.push_back(e);
    end
    if (i_rst) begin
      va = 0; vb = 1; vt = 0; lea = 1'b0; mvalid = 1;
    end else begin
      if (ld_eff) begin
        lv    = int'(i_lt) * 10 + int'(i_lo);
        legal = (i_lt <= 9) && (i_lo <= 9) && (lv <= 59);
        if (legal) va = lv;
        lea = !legal;
      end else begin
        lea = 1'b0;
        if (i_en) va = nxt(va, i_up, 0, 59);
      end
      if (i_en) begin
        vb = nxt(vb, i_up, 1, 12);
        vt = (vt + 1) % 3600;
      end
    end
  endtask

  // Monitor: one record per cycle, compared away from the active edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (m_co === 1'b1) mco_seen++;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("a_count", {a_t, a_o}, r.a_cnt);
        chk("a_co", 8'(a_co), 8'(r.a_co));
        chk("a_bo", 8'(a_bo), 8'(r.a_bo));
        chk("a_at_max", 8'(a_mx), 8'(r.a_mx));
        chk("a_at_min", 8'(a_mn), 8'(r.a_mn));
`ifdef BCD_MODCNT_LOAD_EN
        chk("a_load_err", 8'(a_le), 8'(r.a_le));
        chk("b_load_err", 8'(b_le), 8'd0);
`endif
        chk("b_count", {b_t, b_o}, r.b_cnt);
        chk("b_co", 8'(b_co), 8'(r.b_co));
        chk("b_bo", 8'(b_bo), 8'(r.b_bo));
        chk("b_at_max", 8'(b_mx), 8'(r.b_mx));
        chk("b_at_min", 8'(b_mn), 8'(r.b_mn));
        chk("secs_count", {s_t, s_o}, r.s_cnt);
        chk("mins_count", {m_t, m_o}, r.m_cnt);
        chk("mins_co", 8'(m_co), 8'(r.m_co));
      end
    end
  end

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("sb_drained", 8'(sb.size()), 8'd0);
  endtask

  initial begin
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // Full up sweep through the wrap of both ranges.
    repeat (62) step(0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (62) step(0, 1, 0, 0, 0, 0);
    // Reset in the middle of counting, with en high.
    step(1, 0, 1, 0, 0, 0);
    repeat (37) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 0);
`ifdef BCD_MODCNT_LOAD_EN
    step(0, 0, 1, 1, 4'd5, 4'd9);
    step(0, 1, 1, 1, 4'd4, 4'd5);
    step(0, 0, 1, 1, 4'd6, 4'd0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 4'd2, 4'hA);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 4'd0, 4'd0);
    step(0, 1, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
    end
    // Cascade: a full hour of seconds returns both stages to 00.
    step(1, 0, 1, 0, 0, 0);
    mco_seen = 0;
    repeat (3600) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    drain();
    chk("casc_secs_final", {s_t, s_o}, 8'h00);
    chk("casc_mins_final", {m_t, m_o}, 8'h00);
    chk("mins_co_pulses", 8'(mco_seen), 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_modcnt.md
Name: bcd_modcnt

Overview:
- Two-digit BCD modulo counter; generalised successor of the seconds/ten-seconds counter used in the clock datapath.
- Counts up or down between MIN_VAL and MAX_VAL, both parameters, in packed BCD; covers sec/min (0-59), 24 h (0-23), 12 h (1-12) and day-of-month style ranges.
- Gives combinational carry/borrow for cascading: the next stage's enable is this stage's carry.
- Optional synchronous load for time-setting.

Parameters:
- MIN_VAL, 0, lowest count value as a decimal integer 0..98.
- MAX_VAL, 59, highest count value as a decimal integer MIN_VAL+1..99.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous active-high reset.
- en  in  1  count-step qualifier, one-cycle pulse (e.g. en1hz or upstream co); held high = count every clk.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled with en.
- ones  out  4  BCD units digit, registered.
- tens  out  4  BCD tens digit, registered.
- co  out  1  carry: en & up & (count==MAX_VAL), combinational.
- bo  out  1  borrow: en & ~up & (count==MIN_VAL), combinational.
- at_max  out  1  count==MAX_VAL, from registers only.
- at_min  out  1  count==MIN_VAL, from registers only.
- load  in  1  load strobe; present only with BCD_MODCNT_LOAD_EN.
- load_tens  in  4  BCD tens to load; present only with BCD_MODCNT_LOAD_EN.
- load_ones  in  4  BCD units to load; present only with BCD_MODCNT_LOAD_EN.
- load_err  out  1  registered one-cycle pulse, load rejected; present only with BCD_MODCNT_LOAD_EN.

Behaviour:
- Reset: rst=1 at a clk edge sets {tens,ones} to the BCD of MIN_VAL and clears load_err. rst overrides load and en, including mid-count; co/bo follow the reset value on the next cycle.
- Priority per clk edge: rst > load > en. With no qualifying event the count holds.
- Increment (en=1, up=1):
  - ones!=9 and count!=MAX_VAL: ones+1.
  - ones==9 and count!=MAX_VAL: ones=0, tens+1.
  - count==MAX_VAL: wrap to MIN_VAL; co=1 in the same cycle.
- Decrement (en=1, up=0):
  - ones!=0 and count!=MIN_VAL: ones-1.
  - ones==0 and count!=MIN_VAL: ones=9, tens-1.
  - count==MIN_VAL: wrap to MAX_VAL; bo=1 in the same cycle.
- Latency: outputs change 1 clk after the qualifying edge. co/bo are valid combinationally in the cycle en is high, so cascaded stages update on the same edge.
- Digits are never outside 0-9. The count is never outside MIN_VAL..MAX_VAL from reset or count operations.
- MAX_VAL tens digit may be non-zero while its units digit is below 9 (e.g. 23, 12). The wrap compare is on the full two-digit value, never on the units digit alone.
- Invalid parameters (MIN_VAL>=MAX_VAL, MAX_VAL>99) are an elaboration-time error, via a generate-time $error or an equivalent check.
- All state is in the clk domain. There are no latches, and no asynchronous paths except the co/bo decode.

Optional Feature:
- Macro: BCD_MODCNT_LOAD_EN.
- Defined:
  - load=1 with a legal value (both digits 0-9, value in MIN_VAL..MAX_VAL) writes {load_tens,load_ones} on that edge. The en step for that cycle is discarded and co/bo are forced 0 that cycle.
  - load=1 with an illegal value leaves the count unchanged, discards the en step for that cycle, and sets load_err=1 for exactly the next cycle.
- Not defined: the load, load_tens, load_ones and load_err ports are absent, and the counter has only rst and en paths.

Test Plan:
- Default params, up=1, en every cycle from reset: 00,01..09,10..59,00. co=1 only in the cycle count=59 with en=1. at_max=1 exactly while count=59.
- Default params, up=0 from reset: 00 -> 59 with bo=1 in the 00 cycle, then 58,57..50,49..00.
- MIN_VAL=1, MAX_VAL=12, up=1: reset value 01, sequence 01..09,10,11,12,01. co in the 12 cycle. Count never shows 00 or 13.
- Two instances cascaded (secs 0-59 co -> mins en): after 3600 en pulses both read 00. The mins stage carry pulses exactly once at 59:59.
- rst asserted at count=37 together with en=1: next cycle count=00, co=0. Counting resumes from 00.
- With BCD_MODCNT_LOAD_EN and default params:
  - load 4/5 with en=1: count=45, co=0.
  - load 6/0: count unchanged, load_err=1 for exactly one cycle.
  - load 2/A: count unchanged, load_err=1.
